// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch and instruction-register stage.
//
// Fetches 16-bit words from instruction memory with a req/ack handshake,
// latches each word into the instruction register, and offers it to decode
// as opcode/operand fields with a valid/ready handshake. Owns the program
// counter: it increments after each fetch and is redirected by branches.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   fetch_en                     allow new fetches to start
//   mem_req, mem_addr            fetch request and address (always the PC)
//   mem_ack, mem_rdata           memory response; word valid when mem_ack=1
//   branch_valid, branch_addr    PC redirect, highest priority in every state
//   instr_valid, instr_ready     handshake toward decode
//   opcode_out, operand_out      upper / lower fields of the instruction register
//   pc_out                       address of the instruction held in ir
module fetch_unit #(
    parameter int DATA_WIDTH    = 16,
    parameter int OPERAND_WIDTH = 11,
    parameter int OPCODE_WIDTH  = 5,
    parameter int ADDR_WIDTH    = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_en,
    output logic                     mem_req,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    input  logic                     mem_ack,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    input  logic                     branch_valid,
    input  logic [ADDR_WIDTH-1:0]    branch_addr,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [OPCODE_WIDTH-1:0]  opcode_out,
    output logic [OPERAND_WIDTH-1:0] operand_out,
    output logic [ADDR_WIDTH-1:0]    pc_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [DATA_WIDTH-1:0]   ir;

    // mem_req and instr_valid are kept as registers updated together with
    // state, so each is exactly "state is REQ" / "state is HOLD".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            ir          <= '0;
            pc_out      <= '0;
            mem_req     <= 1'b0;
            instr_valid <= 1'b0;
        end else if (branch_valid) begin
            // Redirect wins over everything: a word returned this cycle is
            // dropped and any held instruction is abandoned.
            pc          <= branch_addr;
            state       <= fetch_en ? REQ : IDLE;
            mem_req     <= fetch_en;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_en) begin
                        state   <= REQ;
                        mem_req <= 1'b1;
                    end
                end
                REQ: begin
                    // Request stays up until acknowledged, regardless of fetch_en.
                    if (mem_ack) begin
                        ir          <= mem_rdata;
                        pc_out      <= pc;
                        pc          <= pc + ADDR_WIDTH'(1);
                        state       <= HOLD;
                        mem_req     <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        state       <= fetch_en ? REQ : IDLE;
                        mem_req     <= fetch_en;
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    mem_req     <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr    = pc;
    assign opcode_out  = ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign operand_out = ir[OPERAND_WIDTH-1:0];

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch and instruction-register stage, directly upstream of the operand sign-extender (ext). It drives a request/acknowledge fetch from instruction memory and latches the returned 16-bit word. It then presents the word split into a 5-bit opcode (to control) and an 11-bit operand (to ext_in), using a valid/ready handshake toward decode. It also owns the program counter, including sequential increment and branch redirect.

Parameters:
DATA_WIDTH, 16, instruction word width
OPERAND_WIDTH, 11, operand field width (feeds ext_in)
OPCODE_WIDTH, 5, opcode field width; OPCODE_WIDTH + OPERAND_WIDTH must equal DATA_WIDTH
ADDR_WIDTH, 11, program counter / instruction address width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
fetch_en  input  1  enables starting new fetches
mem_req  output  1  fetch request to instruction memory
mem_addr  output  ADDR_WIDTH  fetch address (current PC)
mem_ack  input  1  memory returns mem_rdata this cycle
mem_rdata  input  DATA_WIDTH  instruction word, valid when mem_ack=1
branch_valid  input  1  redirect PC this cycle
branch_addr  input  ADDR_WIDTH  redirect target
instr_valid  output  1  opcode_out/operand_out hold a valid instruction
instr_ready  input  1  decode accepts the instruction
opcode_out  output  OPCODE_WIDTH  ir[DATA_WIDTH-1 : OPERAND_WIDTH]
operand_out  output  OPERAND_WIDTH  ir[OPERAND_WIDTH-1 : 0], wired to ext_in
pc_out  output  ADDR_WIDTH  address of the instruction currently in ir

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high. While rst=1: state=IDLE, pc=0, ir=0, pc_out=0, mem_req=0, mem_addr=0, instr_valid=0, opcode_out=0, operand_out=0.
- Moore FSM with three states: IDLE, REQ, HOLD.
- mem_req=1 only in REQ. mem_addr=pc at all times, so it is stable while in REQ. instr_valid=1 only in HOLD.
- IDLE: fetch_en=1 moves to REQ; otherwise stays in IDLE.
- REQ:
  - Request held until mem_ack, even if fetch_en drops.
  - On mem_ack: ir<=mem_rdata, pc_out<=pc, pc<=pc+1 (modulo 2^ADDR_WIDTH, so 0x7FF wraps to 0x000), then go to HOLD.
- HOLD:
  - ir, opcode_out, operand_out and pc_out stay stable until the handshake completes.
  - On instr_ready=1, the transfer completes. Next state is REQ if fetch_en=1, else IDLE.
  - instr_ready is ignored outside HOLD.
- Latency: fetch_en seen at edge N gives REQ at N+1. mem_ack in that cycle gives instr_valid at N+2. Back-to-back throughput is one instruction per 2 cycles plus memory wait.
- branch_valid has highest priority in every state:
  - pc<=branch_addr. Next state is REQ if fetch_en=1, else IDLE.
  - REQ with mem_ack in the same cycle: the returned word is discarded, and ir and pc_out are unchanged.
  - HOLD: the held instruction is dropped, and instr_valid=0 next cycle. If instr_ready=1 in the same cycle, the handshake counts as completed; the outcome is identical.
  - IDLE: only pc is loaded.
- Output decoding is purely from ir: opcode_out = ir[15:11], operand_out = ir[10:0]. No sign handling is done here; ext performs it.
- Reset asserted mid-operation (any state, including REQ awaiting ack) returns to reset values immediately. A late mem_ack after reset is ignored because the FSM is in IDLE.

Test Plan:
1. Reset, fetch_en=1, memory acks next cycle with 0x8801 at addr 0 -> mem_req=1 with mem_addr=0x000. Next cycle instr_valid=1, opcode_out=5'b10001, operand_out=11'b00000000001, pc_out=0, and pc advances to 1.
2. Hold instr_ready=0 for 3 cycles in HOLD -> instr_valid stays 1 and outputs are unchanged. instr_ready=1 with fetch_en=1 -> REQ with mem_addr=0x001.
3. Delay mem_ack 4 cycles and drop fetch_en after the first REQ cycle -> mem_req stays 1 with mem_addr constant until ack. After instr_ready=1 the FSM goes to IDLE.
4. branch_valid=1, branch_addr=0x123 coinciding with mem_ack (rdata 0xFFFF) -> word discarded, instr_valid stays 0, next REQ has mem_addr=0x123.
5. branch_addr=0x7FF, fetch ack -> pc wraps: the following request uses mem_addr=0x000, and pc_out=0x7FF.
6. Assert rst while in REQ, then pulse mem_ack after release -> all outputs 0, FSM remains in IDLE, ir unchanged at 0.
